data_memory_responder: RTL and testbench
========================================

DATA_MEMORY_RESPONDER -- requirements
Module: data_memory_responder

Interface
REQ-001 Parameter DEPTH_WORDS, default 64, is the number of 32-bit words stored (power of two, 16..1024).
REQ-002 Parameter LATENCY, default 2, is the number of cycles from request acceptance to the response cycle (1..15).
REQ-003 clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 memReadInput  input  1  read request from the memory stage.
REQ-006 memWriteInput  input  1  write request from the memory stage.
REQ-007 addressInput  input  32  byte address (ALU result); word index = addressInput[log2(DEPTH_WORDS)+1:2], higher bits ignored (aliasing).
REQ-008 writeDataInput  input  32  store data.
REQ-009 readDataOutput  output  32  registered load data.
REQ-010 readValidOutput  output  1  high for exactly the response cycle of an accepted aligned read.
REQ-011 stallOutput  output  1  pipeline hold; request inputs must stay stable while high.
REQ-012 errorOutput  output  1  high for the response cycle of a misaligned request.

Function
REQ-013 The responder SHALL implement states IDLE, BUSY, DONE.
REQ-014 A request SHALL exist when memReadInput or memWriteInput is high; both high SHALL be treated as a write only (no readValidOutput).
REQ-015 In IDLE with a request, the block SHALL latch kind, address and data, load a counter with LATENCY-1, and go to BUSY (or directly to DONE when LATENCY=1).
REQ-016 In BUSY the counter SHALL decrement each cycle; when counter equals 1 the next state SHALL be DONE.
REQ-017 DONE SHALL last exactly one cycle and always return to IDLE; request inputs seen in DONE SHALL be ignored (they belong to the completing instruction).
REQ-018 stallOutput SHALL be combinational: high when (IDLE and a request is present) or state is BUSY; low in DONE and in IDLE without request.
REQ-019 For a request first presented in cycle T, DONE SHALL occur in cycle T+LATENCY; stallOutput is high for cycles T..T+LATENCY-1.
REQ-020 An aligned write SHALL update the addressed word on the clock edge entering DONE.
REQ-021 An aligned read SHALL register the addressed word into readDataOutput on the edge entering DONE and assert readValidOutput during DONE.
REQ-022 readDataOutput SHALL hold its last value outside DONE; readValidOutput and errorOutput SHALL be low outside DONE.
REQ-023 A request with addressInput[1:0] != 0 SHALL complete with identical timing, perform no write, set readDataOutput to 0 for a read, and assert errorOutput during DONE.
REQ-024 A read of a word written by the immediately preceding write SHALL return the new data.
REQ-025 With no request in IDLE, the block SHALL remain in IDLE with all outputs low except readDataOutput (holds).

Reset
REQ-026 Asserting reset SHALL immediately force IDLE, counter 0, readDataOutput 0, readValidOutput 0, errorOutput 0, and clear every memory word to 0.
REQ-027 Reset asserted during BUSY SHALL abort the operation; the pending write SHALL NOT occur.
REQ-028 After reset release, a request present in the first cycle SHALL be accepted as a normal IDLE request.

Verification
REQ-029 LATENCY=2: write 0xDEADBEEF to address 0x10 at cycle T -> stallOutput high T,T+1; low at T+2; word 4 equals 0xDEADBEEF after edge entering T+2.
REQ-030 Then read address 0x10 -> readValidOutput high exactly one cycle at T'+2 with readDataOutput 0xDEADBEEF; errorOutput low.
REQ-031 Read address 0x12 (misaligned) -> errorOutput high in DONE, readDataOutput 0, readValidOutput low; write to 0x13 leaves memory unchanged.
REQ-032 Write 0x11111111 to 0x20, assert reset one cycle into BUSY -> state IDLE, outputs 0, read of 0x20 after release returns 0x00000000.
REQ-033 memReadInput and memWriteInput both high with data 0x5A5A5A5A at 0x04 -> write occurs, readValidOutput stays low; subsequent read returns 0x5A5A5A5A.
REQ-034 LATENCY=1 and address 0x100 with DEPTH_WORDS=64 -> DONE at T+1, stall one cycle, access aliases to word 0.

Source files
------------

// File: rtl/data_memory_responder.sv
// Fixed-latency data memory responder for a pipeline memory stage.
// Accepts one read or write at a time, holds the pipeline with stallOutput
// for LATENCY cycles, then presents the result for a single DONE cycle.
module data_memory_responder #(
    parameter int DEPTH_WORDS = 64,
    parameter int LATENCY     = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        memReadInput,
    input  logic        memWriteInput,
    input  logic [31:0] addressInput,
    input  logic [31:0] writeDataInput,
    output logic [31:0] readDataOutput,
    output logic        readValidOutput,
    output logic        stallOutput,
    output logic        errorOutput
);

    localparam int IDX_W = $clog2(DEPTH_WORDS);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic              is_write_q, is_write_d;
    logic              is_read_q, is_read_d;
    logic              misal_q, misal_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [31:0]       rdata_q, rdata_d;
    logic              rvalid_q, rvalid_d;
    logic              err_q, err_d;
    logic [31:0]       mem_q [DEPTH_WORDS];

    logic              req;
    logic              live_write, live_read, live_misal;
    logic [IDX_W-1:0]  live_idx;
    logic              op_write, op_read, op_misal;
    logic [IDX_W-1:0]  op_idx;
    logic [31:0]       op_wdata;
    logic              entering_done;
    logic              mem_we;

    // Decode the live request and pick the operand set that completes next:
    // live inputs when finishing straight from IDLE, latched copy otherwise.
    always_comb begin
        req        = memReadInput | memWriteInput;
        live_write = memWriteInput;
        live_read  = memReadInput & ~memWriteInput;
        live_idx   = addressInput[IDX_W+1:2];
        live_misal = |addressInput[1:0];
        if (state_q == IDLE) begin
            op_write = live_write;
            op_read  = live_read;
            op_misal = live_misal;
            op_idx   = live_idx;
            op_wdata = writeDataInput;
        end else begin
            op_write = is_write_q;
            op_read  = is_read_q;
            op_misal = misal_q;
            op_idx   = idx_q;
            op_wdata = wdata_q;
        end
    end

    // Next-state, latency counter, request capture and stall generation.
    always_comb begin
        // NOTE: every output of this block gets a default first so no path leaves it unassigned (no latches).
        state_d     = state_q;
        cnt_d       = cnt_q;
        is_write_d  = is_write_q;
        is_read_d   = is_read_q;
        misal_d     = misal_q;
        idx_d       = idx_q;
        wdata_d     = wdata_q;
        stallOutput = 1'b0;
        case (state_q)
            IDLE: begin
                if (req) begin
                    stallOutput = 1'b1;
                    is_write_d  = live_write;
                    is_read_d   = live_read;
                    misal_d     = live_misal;
                    idx_d       = live_idx;
                    wdata_d     = writeDataInput;
                    cnt_d       = 4'(LATENCY - 1);
                    state_d     = (LATENCY == 1) ? DONE : BUSY;
                end
            end
            BUSY: begin
                stallOutput = 1'b1;
                cnt_d       = cnt_q - 4'd1;
                if (cnt_q == 4'd1) state_d = DONE;
            end
            DONE: begin
                // Inputs still present here belong to the completing instruction.
                cnt_d   = 4'd0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Result generation on the edge that enters DONE.
    always_comb begin
        entering_done = (state_d == DONE);
        mem_we        = entering_done & op_write & ~op_misal;
        rvalid_d      = entering_done & op_read & ~op_misal;
        err_d         = entering_done & op_misal;
        rdata_d       = rdata_q;
        if (entering_done && op_read) rdata_d = op_misal ? 32'd0 : mem_q[op_idx];
    end

    // Control and output registers.
    always_ff @(posedge clk or posedge reset) begin
        // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
        if (reset) begin
            state_q    <= IDLE;
            cnt_q      <= 4'd0;
            is_write_q <= 1'b0;
            is_read_q  <= 1'b0;
            misal_q    <= 1'b0;
            idx_q      <= '0;
            wdata_q    <= 32'd0;
            rdata_q    <= 32'd0;
            rvalid_q   <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            is_write_q <= is_write_d;
            is_read_q  <= is_read_d;
            misal_q    <= misal_d;
            idx_q      <= idx_d;
            wdata_q    <= wdata_d;
            rdata_q    <= rdata_d;
            rvalid_q   <= rvalid_d;
            err_q      <= err_d;
        end
    end

    // Word storage; cleared by reset, written on the edge entering DONE.
    always_ff @(posedge clk or posedge reset) begin
        // NOTE: the storage is reset word-by-word because the block must come out of reset all-zero; this forces flops, not RAM macros.
        if (reset) begin
            for (int i = 0; i < DEPTH_WORDS; i++) mem_q[i] <= 32'd0;
        end else if (mem_we) begin
            mem_q[op_idx] <= op_wdata;
        end
    end

    assign readDataOutput  = rdata_q;
    assign readValidOutput = rvalid_q;
    assign errorOutput     = err_q;

endmodule

// File: tb/tb_data_memory_responder.sv
// Scoreboard bench for data_memory_responder: directed requests push the
// expected DONE-cycle response; a monitor pops and compares it.
module tb_data_memory_responder;

    localparam int LAT = 2;

    typedef struct {
        logic        valid;
        logic        err;
        logic [31:0] data;
        logic        chk_data;
    } resp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        rd = 1'b0, wr = 1'b0;
    logic [31:0] addr = '0, wdata = '0;
    logic [31:0] rdata;
    logic        rv, stall, err;

    logic        rd1 = 1'b0, wr1 = 1'b0;
    logic [31:0] addr1 = '0, wdata1 = '0;
    logic [31:0] rdata1;
    logic        rv1, stall1, err1;

    int    n_checks = 0;
    int    n_fail   = 0;
    resp_t sb[$];

    data_memory_responder #(.DEPTH_WORDS(64), .LATENCY(LAT)) dut (
        .clk(clk), .reset(reset),
        .memReadInput(rd), .memWriteInput(wr),
        .addressInput(addr), .writeDataInput(wdata),
        .readDataOutput(rdata), .readValidOutput(rv),
        .stallOutput(stall), .errorOutput(err)
    );

    data_memory_responder #(.DEPTH_WORDS(64), .LATENCY(1)) dut1 (
        .clk(clk), .reset(reset),
        .memReadInput(rd1), .memWriteInput(wr1),
        .addressInput(addr1), .writeDataInput(wdata1),
        .readDataOutput(rdata1), .readValidOutput(rv1),
        .stallOutput(stall1), .errorOutput(err1)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: any DONE-cycle response must match the oldest expectation.
    always @(negedge clk) begin
        if (!reset && (rv || err)) begin
            if (sb.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_resp: got rv=%b err=%b data=%h expected none at %0t", rv, err, rdata, $time);
            end else begin
                resp_t e;
                e = sb.pop_front();
                check("resp_valid", {31'd0, rv}, {31'd0, e.valid});
                check("resp_err", {31'd0, err}, {31'd0, e.err});
                if (e.chk_data) check("resp_data", rdata, e.data);
            end
        end
    end

    // Issue one request on the LATENCY=2 instance, starting just after an edge.
    task automatic issue(input logic r, input logic w, input logic [31:0] a, input logic [31:0] d,
                         input logic has_resp, input logic e_valid, input logic e_err,
                         input logic [31:0] e_data, input logic e_chk);
        resp_t x;
        if (has_resp) begin
            x.valid = e_valid; x.err = e_err; x.data = e_data; x.chk_data = e_chk;
            sb.push_back(x);
        end
        rd = r; wr = w; addr = a; wdata = d;
        for (int i = 0; i < LAT; i++) begin
            @(negedge clk);
            check("stall_hold", {31'd0, stall}, 32'd1);
            @(posedge clk); #1;
        end
        // DONE cycle: inputs remain asserted and must be ignored.
        @(negedge clk);
        check("stall_done", {31'd0, stall}, 32'd0);
        @(posedge clk); #1;
        rd = 1'b0; wr = 1'b0;
        @(negedge clk);
        check("stall_idle", {31'd0, stall}, 32'd0);
        check("idle_valid", {31'd0, rv}, 32'd0);
        @(posedge clk); #1;
    endtask

    initial begin
        #2;
        check("rst_rdata", rdata, 32'd0);
        check("rst_valid", {31'd0, rv}, 32'd0);
        check("rst_err", {31'd0, err}, 32'd0);
        check("rst_stall", {31'd0, stall}, 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;

        // Aligned write then read-back of word 4.
        issue(1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
        issue(1'b1, 1'b0, 32'h10, 32'h0, 1'b1, 1'b1, 1'b0, 32'hDEADBEEF, 1'b1);
        check("rdata_hold", rdata, 32'hDEADBEEF);

        // Misaligned read and write; word 4 must be untouched.
        issue(1'b1, 1'b0, 32'h12, 32'h0, 1'b1, 1'b0, 1'b1, 32'h0, 1'b1);
        issue(1'b0, 1'b1, 32'h13, 32'hFFFFFFFF, 1'b1, 1'b0, 1'b1, 32'h0, 1'b0);
        issue(1'b1, 1'b0, 32'h10, 32'h0, 1'b1, 1'b1, 1'b0, 32'hDEADBEEF, 1'b1);

        // Read and write together behave as a write only.
        issue(1'b1, 1'b1, 32'h04, 32'h5A5A5A5A, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
        issue(1'b1, 1'b0, 32'h04, 32'h0, 1'b1, 1'b1, 1'b0, 32'h5A5A5A5A, 1'b1);

        // Reset one cycle into BUSY aborts the write and clears everything.
        rd = 1'b0; wr = 1'b1; addr = 32'h20; wdata = 32'h11111111;
        @(posedge clk); #1;
        check("busy_stall", {31'd0, stall}, 32'd1);
        reset = 1'b1; wr = 1'b0;
        #1;
        check("abort_stall", {31'd0, stall}, 32'd0);
        check("abort_rdata", rdata, 32'd0);
        check("abort_valid", {31'd0, rv}, 32'd0);
        check("abort_err", {31'd0, err}, 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        // Request present in the first cycle after release.
        issue(1'b1, 1'b0, 32'h20, 32'h0, 1'b1, 1'b1, 1'b0, 32'h00000000, 1'b1);
        issue(1'b1, 1'b0, 32'h10, 32'h0, 1'b1, 1'b1, 1'b0, 32'h00000000, 1'b1);

        // LATENCY=1 instance: address 0x100 aliases to word 0.
        wr1 = 1'b1; addr1 = 32'h100; wdata1 = 32'hCAFEF00D;
        @(negedge clk);
        check("l1_stall_req", {31'd0, stall1}, 32'd1);
        @(posedge clk); #1;
        @(negedge clk);
        check("l1_stall_done", {31'd0, stall1}, 32'd0);
        check("l1_wr_valid", {31'd0, rv1}, 32'd0);
        check("l1_wr_err", {31'd0, err1}, 32'd0);
        @(posedge clk); #1;
        wr1 = 1'b0;
        @(negedge clk);
        check("l1_idle_stall", {31'd0, stall1}, 32'd0);
        @(posedge clk); #1;
        rd1 = 1'b1; addr1 = 32'h0;
        @(negedge clk);
        check("l1_rd_stall", {31'd0, stall1}, 32'd1);
        check("l1_rd_early", {31'd0, rv1}, 32'd0);
        @(posedge clk); #1;
        @(negedge clk);
        check("l1_rd_valid", {31'd0, rv1}, 32'd1);
        check("l1_rd_data", rdata1, 32'hCAFEF00D);
        @(posedge clk); #1;
        rd1 = 1'b0;
        @(negedge clk);
        check("l1_rd_drop", {31'd0, rv1}, 32'd0);
        check("l1_rd_hold", rdata1, 32'hCAFEF00D);

        repeat (3) @(posedge clk);
        #1;
        check("sb_empty", sb.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
